mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the instruction-fetch port (IF) and the data-access port (MEM stage).
- Runs a sequential access FSM with a fixed memory latency.
- Pulses a one-cycle valid back to the granted requester and drives per-requester stall signals into the pipeline hazard logic.
- Gives data accesses priority. A starvation counter guarantees forward progress for fetch.

Parameters:
- MEM_LAT, 2, memory latency in cycles; mem_en is held for this many cycles per access; legal range 1..15.
- STARVE_MAX, 4, maximum consecutive data grants while if_req is pending; the next grant goes to IF.
- IF_OP, 3'b010, mem_op code driven for fetches (word load, funct3 encoding).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched word; meaningful when if_valid=1.
- if_valid  out  1  one-cycle completion pulse for a fetch.
- if_stall  out  1  equals if_req & ~if_valid (combinational).
- d_req  in  1  data request; held high until d_valid.
- d_addr  in  32  data address (ALU result).
- d_wdata  in  32  store data (rs2 value).
- d_op  in  3  memory op code, passed through opaquely.
- d_rdata  out  32  load data; meaningful when d_valid=1.
- d_valid  out  1  one-cycle completion pulse for a data access.
- d_stall  out  1  equals d_req & ~d_valid (combinational).
- mem_en  out  1  memory access enable.
- mem_addr  out  32  latched access address.
- mem_wdata  out  32  latched store data; 0 for fetches.
- mem_op  out  3  latched op code (IF_OP or d_op).
- mem_rdata  in  32  memory read data; valid in the last mem_en cycle.

Behaviour:
- Reset values (asynchronous): state=IDLE, owner=0, lat_cnt=0, starve_cnt=0, all *_valid=0, mem_en=0, mem_addr/mem_wdata/mem_op=0, if_rdata/d_rdata=0. *_stall follow their combinational definitions.
- FSM states are IDLE, ACCESS and DONE.
- IDLE, no request: stay in IDLE.
- IDLE, request present, grant decision:
  - If d_req=1 and not (if_req=1 and starve_cnt==STARVE_MAX): grant D.
  - Otherwise, if if_req=1: grant IF.
- On a grant:
  - Latch owner.
  - Latch addr, wdata (0 for IF) and op (IF_OP for IF).
  - Set lat_cnt=MEM_LAT-1 and go to ACCESS.
- ACCESS:
  - mem_en=1 and the latched outputs are stable.
  - If lat_cnt==0: capture mem_rdata into the owner's rdata register and go to DONE.
  - Otherwise: decrement lat_cnt.
- DONE:
  - Owner's *_valid=1 for exactly this cycle; mem_en=0.
  - Return to IDLE.
  - The non-owner's rdata register holds its previous value.
- Latency: from the request being sampled in IDLE at cycle t, valid is asserted at cycle t+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles.
- Starvation counter:
  - D grant while if_req=1: starve_cnt++ (saturating at STARVE_MAX).
  - IF grant: starve_cnt=0.
  - D grant while if_req=0: starve_cnt=0.
- Stores also complete with a d_valid pulse; d_rdata then holds mem_rdata as captured (don't-care to the requester).
- Simultaneous requests: with data priority, IF waits. if_stall stays high throughout.
- Requester drops req mid-access: the access still completes and valid still pulses. No abort, no write suppression.
- New request arriving during ACCESS or DONE: not sampled until IDLE.
- Inputs changing during ACCESS have no effect, because everything is latched at grant.
- Reset mid-access: immediate return to reset values. No valid is issued and the access is lost.
- mem_addr, mem_wdata and mem_op keep their last latched values outside ACCESS; only mem_en qualifies them.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x100 at t0, mem returns 0x00500093.
  - Response: mem_en high at t1–t2 with mem_addr=0x100 and mem_op=3'b010; if_valid=1 at t3 with if_rdata=0x00500093; if_stall=1 at t0–t2 and 0 at t3.
- Store:
  - Stimulus: d_req=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_op=3'b010.
  - Response: mem_wdata=0xDEADBEEF during both mem_en cycles; d_valid pulses at t3; if_valid stays 0.
- Simultaneous requests:
  - Stimulus: if_req=1 and d_req=1 at t0.
  - Response: D served first (d_valid at t3); IF granted in IDLE at t4; if_valid at t7.
- Starvation:
  - Stimulus: if_req held high while d_req is continuously re-asserted.
  - Response: after 4 D grants the 5th grant goes to IF; starve_cnt then reads 0.
- Request withdrawn:
  - Stimulus: d_req dropped at t1.
  - Response: mem_en still high for t1–t2; d_valid still pulses at t3.
- Reset mid-access:
  - Stimulus: reset asserted at t2 of a fetch.
  - Response: mem_en=0 immediately, if_valid never pulses, state=IDLE. After release, a new fetch completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data requesters
// Data accesses win; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
   parameter int          MEM_LAT    = 2,
   parameter int          STARVE_MAX = 4,
   parameter logic [2:0]  IF_OP      = 3'b010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_stall,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_op,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_stall,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_op,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [3:0]    LAT_INIT   = 4'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;   // 1 = data port, 0 = fetch port
   logic [3:0]    lat_cnt_q, lat_cnt_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [2:0]    mem_op_q, mem_op_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= '0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_op_q     <= 3'd0;
         if_rdata_q   <= 32'd0;
         d_rdata_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_op_q     <= mem_op_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_op_d     = mem_op_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (d_req && !(if_req && starve_cnt_q == STARVE_TOP)) begin
               owner_d     = 1'b1;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_op_d    = d_op;
               lat_cnt_d   = LAT_INIT;
               state_d     = ACCESS;
               if (!if_req)
                  starve_cnt_d = '0;
               else if (starve_cnt_q != STARVE_TOP)
                  starve_cnt_d = starve_cnt_q + 1'b1;
            end else if (if_req) begin
               owner_d      = 1'b0;
               mem_addr_d   = if_addr;
               mem_wdata_d  = 32'd0;
               mem_op_d     = IF_OP;
               lat_cnt_d    = LAT_INIT;
               starve_cnt_d = '0;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            if (lat_cnt_q == 4'd0) begin
               if (owner_q)
                  d_rdata_d = mem_rdata;
               else
                  if_rdata_d = mem_rdata;
               state_d = DONE;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Valids and mem_en decode straight from state so reset clears them immediately.
   assign mem_en    = (state_q == ACCESS);
   assign if_valid  = (state_q == DONE) && !owner_q;
   assign d_valid   = (state_q == DONE) && owner_q;
   assign if_stall  = if_req & ~if_valid;
   assign d_stall   = d_req & ~d_valid;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_op    = mem_op_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule
